// File: rtl/sobel_window_sched_pkg.sv
// sobel_pkg: shared definitions for the Sobel window scheduler.
//   state_t    - frame sequencing states (IDLE, RUN, DONE)
//   TAP_*      - tap index inside a 3x3 window, k = 3*dr + dc, TL = 0
//   idx_width  - width of a counter that can hold 0..rows*cols inclusive
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  function automatic int idx_width(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/sobel_window_sched_if.sv
// sobel_window_sched_if: pixel input stream and window output stream of the
// Sobel window scheduler.
//   pix_valid/pix_ready/pix_data        - raster-order pixel stream into the scheduler
//   win_valid/win_ready                 - window slot handshake out of the scheduler
//   win_data/win_border/win_row/win_col - window payload (9 taps, TL at LSBs)
// master: the scheduler (consumes pixels, produces windows)
// slave : the surrounding environment (source + gradient stage)
interface sobel_window_sched_if #(
  parameter int ROWS  = 242,
  parameter int COLS  = 247,
  parameter int PIX_W = 8
);

  logic                     pix_valid;
  logic                     pix_ready;
  logic [PIX_W-1:0]         pix_data;
  logic                     win_valid;
  logic                     win_ready;
  logic [9*PIX_W-1:0]       win_data;
  logic                     win_border;
  logic [$clog2(ROWS)-1:0]  win_row;
  logic [$clog2(COLS)-1:0]  win_col;

  modport master (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, win_data, win_border, win_row, win_col
  );

  modport slave (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, win_data, win_border, win_row, win_col
  );

endinterface

// File: rtl/sobel_window_sched_line_store.sv
// sobel_line_store: 3*COLS-deep circular pixel buffer.
//   clk    - write clock
//   we     - write enable
//   waddr  - write address (0 .. 3*COLS-1)
//   wdata  - pixel to store
//   centre - buffer address of the window centre pixel
//   taps   - 9 combinational taps, tap k = 3*dr+dc at [PIX_W*k +: PIX_W]
// Reads see pre-edge contents, so a write on the same edge as a window load
// never disturbs that window.
module sobel_line_store
  import sobel_pkg::*;
#(
  parameter int COLS  = 247,
  parameter int PIX_W = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [$clog2(3*COLS)-1:0] waddr,
  input  logic [PIX_W-1:0]          wdata,
  input  logic [$clog2(3*COLS)-1:0] centre,
  output logic [9*PIX_W-1:0]        taps
);

  localparam int DEPTH = 3 * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW+1:0] D1 = (AW+2)'(DEPTH);
  localparam logic [AW+1:0] D2 = (AW+2)'(2 * DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];

  // Bring centre + DEPTH + offset (always in [0, 3*DEPTH)) back into the buffer.
  function automatic logic [AW-1:0] wrap_addr(input logic [AW+1:0] s);
    logic [AW+1:0] r;
    if (s >= D2)      r = s - D2;
    else if (s >= D1) r = s - D1;
    else              r = s;
    return r[AW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Offsets are biased by DEPTH so the sum never goes negative.
  for (genvar k = TAP_TL; k <= TAP_BR; k++) begin : g_tap
    localparam int OFS = DEPTH + (k / 3 - 1) * COLS + (k % 3 - 1);
    logic [AW+1:0] sum;
    assign sum = {2'b00, centre} + (AW+2)'(OFS);
    assign taps[PIX_W*k +: PIX_W] = mem[wrap_addr(sum)];
  end

endmodule

// File: rtl/sobel_window_sched.sv
// sobel_window_sched: streams one 3x3 neighbourhood per cycle to the Sobel
// gradient stage, in raster order, one slot per output pixel.
//   clk, rst        - clock, synchronous active-high reset
//   start           - begin a frame (only looked at in IDLE)
//   bus (master)    - pixel input stream and window output stream
//   busy            - high in RUN and DONE
//   done            - one-cycle pulse after the last slot handshake
// Optional build macro SOBEL_SCHED_STATS_EN adds saturating stall counters
//   stall_in_cyc    - RUN cycles with a pixel offered but not accepted
//   stall_out_cyc   - cycles with a slot offered but not taken
module sobel_window_sched
  import sobel_pkg::*;
#(
  parameter int ROWS  = 242,
  parameter int COLS  = 247,
  parameter int PIX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  sobel_window_sched_if.master bus,
  output logic                 busy,
  output logic                 done
`ifdef SOBEL_SCHED_STATS_EN
  ,
  output logic [31:0]          stall_in_cyc,
  output logic [31:0]          stall_out_cyc
`endif
);

  localparam int N     = ROWS * COLS;
  localparam int IW    = idx_width(ROWS, COLS);
  localparam int XW    = IW + 2;
  localparam int DEPTH = 3 * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  state_t          state, state_nx;
  logic [IW-1:0]   n_cnt, o_cnt;
  logic [XW-1:0]   n_x, o_x;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [RW-1:0]   row_cnt;
  logic [CW-1:0]   col_cnt;
  logic            win_last;
  logic [9*PIX_W-1:0] taps;
  logic            slot_border, eligible, load, accept, last_hs, frame_start;

  assign n_x = XW'(n_cnt);
  assign o_x = XW'(o_cnt);

  assign frame_start = (state == IDLE) && start;
  assign slot_border = (row_cnt == '0) || (row_cnt == RW'(ROWS - 1)) ||
                       (col_cnt == '0) || (col_cnt == CW'(COLS - 1));
  // Interior slots wait until pixel (r+1, c+1) is in the buffer.
  assign eligible    = (state == RUN) && (o_x < XW'(N)) &&
                       (slot_border || (n_x >= o_x + XW'(COLS + 2)));
  assign load        = eligible && (!bus.win_valid || bus.win_ready);
  assign accept      = bus.pix_valid && bus.pix_ready;
  assign last_hs     = bus.win_valid && bus.win_ready && win_last;

  // Pixel o+2*COLS-1 lands on the top-left tap of window o. It may only be
  // written while window o is being loaded on the same edge (reads see
  // pre-edge storage) or when window o is a border slot and reads nothing.
  always_comb begin
    bus.pix_ready = 1'b0;
    if (state == RUN && n_x < XW'(N)) begin
      if (n_x < o_x + XW'(2 * COLS - 1))
        bus.pix_ready = 1'b1;
      else if (n_x == o_x + XW'(2 * COLS - 1) && (slot_border || load))
        bus.pix_ready = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_hs) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  sobel_line_store #(
    .COLS  (COLS),
    .PIX_W (PIX_W)
  ) u_store (
    .clk    (clk),
    .we     (accept),
    .waddr  (wr_ptr),
    .wdata  (bus.pix_data),
    .centre (rd_ptr),
    .taps   (taps)
  );

  // Counters, buffer pointers and the output slot register. rd_ptr is the
  // buffer address of pixel o, i.e. the centre of the next window.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      n_cnt          <= '0;
      o_cnt          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      row_cnt        <= '0;
      col_cnt        <= '0;
      win_last       <= 1'b0;
      bus.win_valid  <= 1'b0;
      bus.win_data   <= '0;
      bus.win_border <= 1'b0;
      bus.win_row    <= '0;
      bus.win_col    <= '0;
    end else begin
      if (accept) begin
        n_cnt  <= n_cnt + 1'b1;
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (load) begin
        o_cnt  <= o_cnt + 1'b1;
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        if (col_cnt == CW'(COLS - 1)) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == RW'(ROWS - 1)) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
        bus.win_valid  <= 1'b1;
        bus.win_data   <= slot_border ? '0 : taps;
        bus.win_border <= slot_border;
        bus.win_row    <= row_cnt;
        bus.win_col    <= col_cnt;
        win_last       <= (o_cnt == IW'(N - 1));
      end else if (bus.win_ready) begin
        bus.win_valid <= 1'b0;
        win_last      <= 1'b0;
      end
    end
  end

`ifdef SOBEL_SCHED_STATS_EN
  // Saturating stall counters, restarted with every frame.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      stall_in_cyc  <= '0;
      stall_out_cyc <= '0;
    end else begin
      if (state == RUN && bus.pix_valid && !bus.pix_ready && stall_in_cyc != '1)
        stall_in_cyc <= stall_in_cyc + 1'b1;
      if (bus.win_valid && !bus.win_ready && stall_out_cyc != '1)
        stall_out_cyc <= stall_out_cyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_window_sched.sv
// tb_sobel_window_sched: self-checking bench for sobel_window_sched on a
// 4x5 frame. Expected windows come from a 2D reference model over the
// pixel array fed to the frame.
module tb_sobel_window_sched;

  localparam int R  = 4;
  localparam int C  = 5;
  localparam int PW = 8;
  localparam int NP = R * C;
  localparam int RW = $clog2(R);
  localparam int CW = $clog2(C);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
`ifdef SOBEL_SCHED_STATS_EN
  logic [31:0] stall_in_cyc, stall_out_cyc;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [PW-1:0]   pix [NP];
  int              border_seen;
  logic [9*PW-1:0] slot6_data;

  sobel_window_sched_if #(.ROWS(R), .COLS(C), .PIX_W(PW)) bus ();

  sobel_window_sched #(
    .ROWS  (R),
    .COLS  (C),
    .PIX_W (PW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
`ifdef SOBEL_SCHED_STATS_EN
    ,
    .stall_in_cyc  (stall_in_cyc),
    .stall_out_cyc (stall_out_cyc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic exp_border(input int k);
    int r, c;
    r = k / C;
    c = k % C;
    return (r == 0) || (r == R - 1) || (c == 0) || (c == C - 1);
  endfunction

  function automatic logic [9*PW-1:0] exp_window(input int k);
    int r, c;
    logic [9*PW-1:0] w;
    r = k / C;
    c = k % C;
    w = '0;
    if (!exp_border(k))
      for (int t = 0; t < 9; t++)
        w[PW*t +: PW] = pix[(r + t / 3 - 1) * C + (c + t % 3 - 1)];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame: random pixel gaps / downstream stalls, an optional
  // forced stall of the first presented slots, and an optional start pulse
  // during RUN. Every handshaken slot is compared with the model.
  task automatic applyStimulus(input int valid_pct, input int ready_pct,
                               input int stall_cycles, input int start_pulse_cyc);
    int src, k, cyc, done_cnt, stall_left, extra;
    logic seen_done, stall_check, pv;
    logic [1+RW+CW+9*PW-1:0] got, exp;
    src = 0; k = 0; cyc = 0; done_cnt = 0; extra = 0;
    stall_left = stall_cycles; seen_done = 1'b0;
    border_seen = 0; slot6_data = '0;
    @(posedge clk); #1;
    start = 1'b1; bus.pix_valid = 1'b0; bus.win_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen_done && cyc < 4000) begin
      stall_check = 1'b0;
      start = (cyc == start_pulse_cyc);
      pv = (src < NP) && ($urandom_range(99) < valid_pct);
      bus.pix_valid = pv;
      bus.pix_data  = pv ? pix[(src < NP) ? src : 0] : PW'($urandom);
      if (stall_left > 0 && bus.win_valid) begin
        bus.win_ready = 1'b0;
        stall_left--;
        stall_check = (stall_left == 0);
      end else begin
        bus.win_ready = ($urandom_range(99) < ready_pct);
      end
      @(negedge clk);
      if (stall_check && stall_cycles >= 2 * C) begin
        checkOutput("stall_pix_count", src, 1 + 2 * C);
        checkOutput("stall_pix_ready", bus.pix_ready, 0);
      end
      if (bus.pix_valid && bus.pix_ready) src++;
      if (bus.win_valid && bus.win_ready) begin
        got = {bus.win_border, bus.win_row, bus.win_col, bus.win_data};
        if (k < NP) begin
          exp = {exp_border(k), RW'(k / C), CW'(k % C), exp_window(k)};
          checkOutput($sformatf("slot_%0d", k), got, exp);
          if (k == 6) slot6_data = bus.win_data;
        end
        if (bus.win_border) border_seen++;
        k++;
      end
      if (done) begin
        done_cnt++;
        seen_done = 1'b1;
      end
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("frame_done_seen", seen_done, 1);
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b1;
    @(negedge clk);
    checkOutput("busy_after_done", busy, 0);
    repeat (3) begin
      if (done) done_cnt++;
      if (bus.win_valid) extra++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    checkOutput("slot_count", k + extra, NP);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("pixels_consumed", src, NP);
  endtask

  initial begin
    int src_ab, cyc_ab;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.win_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs",
                {bus.pix_ready, bus.win_valid, bus.win_border, bus.win_row,
                 bus.win_col, bus.win_data, busy, done}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Pixels offered in IDLE are refused
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_pix_ready", bus.pix_ready, 0);
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;

    // Ramp frame, free-flowing
    $display("[TB] ramp frame, no stalls");
    for (int i = 0; i < NP; i++) pix[i] = PW'(i);
    applyStimulus(100, 100, 0, -1);
    checkOutput("border_count", border_seen, 14);
    checkOutput("tap_1_1", slot6_data, 72'h0c0b0a070605020100);

    // Downstream held off after the first slot appears
    $display("[TB] ramp frame, downstream stall");
    applyStimulus(100, 100, 20, -1);
    checkOutput("stall_tap_1_1", slot6_data, 72'h0c0b0a070605020100);

    // start pulsed during RUN must be ignored
    $display("[TB] start pulse during RUN");
    applyStimulus(100, 100, 0, 8);

    // Random pixels, random source gaps and sink stalls
    for (int f = 0; f < 3; f++) begin
      $display("[TB] random frame %0d", f);
      for (int i = 0; i < NP; i++) pix[i] = PW'($urandom);
      applyStimulus(60, 50, 0, -1);
    end

    // Reset mid-frame after 9 pixels, then a fresh frame
    $display("[TB] mid-frame reset");
    for (int i = 0; i < NP; i++) pix[i] = PW'($urandom);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_ab = 0;
    cyc_ab = 0;
    while (src_ab < 9 && cyc_ab < 200) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix[src_ab];
      bus.win_ready = 1'b1;
      @(negedge clk);
      if (bus.pix_ready) src_ab++;
      cyc_ab++;
      @(posedge clk); #1;
    end
    checkOutput("abort_fill", src_ab, 9);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_outputs",
                {bus.pix_ready, bus.win_valid, bus.win_border, bus.win_row,
                 bus.win_col, bus.win_data, busy, done}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    for (int i = 0; i < NP; i++) pix[i] = PW'($urandom);
    applyStimulus(80, 80, 0, -1);

`ifdef SOBEL_SCHED_STATS_EN
    // Exactly three forced sink stalls while a slot is valid
    $display("[TB] stall counters");
    applyStimulus(100, 100, 3, -1);
    checkOutput("stall_out_cyc", stall_out_cyc, 3);
    $display("[TB] stall_in_cyc=%0d", stall_in_cyc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_window_sched.md
Name: sobel_window_sched

Overview:
- Streaming scheduler that feeds the Sobel gradient datapath one 3x3 neighbourhood per cycle, replacing whole-frame array processing.
- Accepts raster-order 8-bit pixels over a valid/ready handshake and buffers them in a 3-line circular store.
- Emits exactly ROWS*COLS window slots in raster order, one per output pixel. Border slots are flagged and zeroed so the kernel writes 0 there.
- Sits between the image source and the gradient/magnitude stage; owns frame sequencing (start/busy/done).

Parameters:
- ROWS, 242, frame height in pixels; must be >= 3.
- COLS, 247, frame width in pixels; must be >= 3.
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- pix_valid  in  1  input pixel valid.
- pix_data  in  PIX_W  input pixel, raster order.
- pix_ready  out  1  scheduler accepts pix_data this cycle.
- win_valid  out  1  window slot valid.
- win_ready  in  1  downstream accepts the slot.
- win_data  out  9*PIX_W  window; tap k = 3*dr+dc sits at [PIX_W*k +: PIX_W], with k=0 top-left.
- win_border  out  1  slot is a frame-border pixel; win_data is all zero.
- win_row  out  $clog2(ROWS)  centre row of the slot.
- win_col  out  $clog2(COLS)  centre column of the slot.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the last slot handshake.

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared.
- N = ROWS*COLS. Counters:
  - n = number of pixels accepted.
  - o = index of the next output slot to load.
- FSM:
  - IDLE -> RUN on start. Clears n, o, pointers, and the output register.
  - RUN -> DONE on the handshake of slot N-1.
  - DONE -> IDLE after 1 cycle; done=1 only during DONE.
  - start outside IDLE is ignored. rst mid-frame aborts immediately, and buffered data is discarded.
- pix_ready = RUN && n < N && n < o + 2*COLS. The second term prevents overwriting rows still needed by window o. Pixels offered outside RUN are not accepted.
- Storage: circular buffer of depth 3*COLS. The write address is n mod 3*COLS, kept as a wrapping pointer with no divider.
- Slot o (row r=o/COLS, col c=o%COLS; tracked as incrementing row/col counters):
  - Border if r==0, r==ROWS-1, c==0, or c==COLS-1.
  - Interior slots are eligible when n >= o + COLS + 2, i.e. pixel (r+1,c+1) has been stored.
  - Border slots are always eligible in RUN.
- Output register: loads slot o when eligible && (!win_valid || win_ready); o then increments.
  - Latency: 1 cycle from eligibility to win_valid.
  - A same-edge write never corrupts a read, because reads sample pre-edge storage.
- win_valid holds, and win_data/row/col/border stay stable, until win_ready. A handshake and a new load may occur in the same cycle, giving 1 slot/cycle sustained.
- Simultaneous pixel accept and slot load are permitted.
- Throughput and ordering do not depend on pix_valid gaps or win_ready stalls.
- Interior taps: tap(dr,dc) = pixel index o + (dr-1)*COLS + (dc-1), addressed mod 3*COLS.

Optional Feature:
- Macro SOBEL_SCHED_STATS_EN.
- When defined: adds outputs stall_in_cyc[31:0] and stall_out_cyc[31:0], both cleared on rst and on start.
  - stall_in_cyc counts RUN cycles with pix_valid && !pix_ready.
  - stall_out_cyc counts cycles with win_valid && !win_ready.
  - Both saturate at all-ones.
- When not defined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sobel_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - tap index constants TAP_TL..TAP_BR (0..8);
  - a function returning index width $clog2(ROWS*COLS+1).
- Sub-module sobel_line_store holds the 3*COLS circular buffer: 1 write port and 9 combinational read taps given a centre address, with wrap handling.

Test Plan:
- ROWS=4, COLS=5, pixels 0..19 streamed with win_ready=1:
  - exactly 20 slots in raster order;
  - 14 with win_border=1 and zero data;
  - interior (1,1) taps = {0,1,2,5,6,7,10,11,12};
  - done pulses once, then busy=0.
- Same frame with win_ready held low after the first slot:
  - pix_ready drops once n reaches o+2*COLS (n=11 with o=1);
  - no pixel is lost after release;
  - tap values still match.
- Random pix_valid gaps plus random win_ready: slot sequence is bit-identical to the no-stall run.
- rst asserted mid-frame (after 9 pixels), then a new start: outputs are 0 on the cycle after rst, and the second frame is correct from slot 0.
- start pulsed during RUN: ignored, and the slot count stays 20. Pixels offered in IDLE: pix_ready=0.
- With SOBEL_SCHED_STATS_EN and 3 forced win_ready-low cycles while valid: stall_out_cyc=3.
